if_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives the fetch address.
- Takes the combinational instruction word returned in the same cycle and registers it into the IF/ID pipeline register for decode.
- Handles decode stalls, EX-stage redirects (taken branch or jump), and fetch faults for misaligned or out-of-range addresses.

---
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_stage : instruction fetch, PC ownership, IF/ID register, fetch faults |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] c_last_addr = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic        r_valid, w_valid_nx;
  logic [31:0] r_instr, w_instr_nx;
  logic [31:0] r_id_pc, w_id_pc_nx;
  logic [31:0] r_id_pc4, w_id_pc4_nx;
  logic        r_fault, w_fault_nx;
  logic [31:0] r_fault_pc, w_fault_pc_nx;

  logic [31:0] w_pc_plus4;
  logic        w_pc_legal;
  logic        w_redir_legal;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_pc_legal    = (r_pc[1:0] == 2'b00) && (r_pc <= c_last_addr);
  assign w_redir_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= c_last_addr);

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_valid_nx    = r_valid;
    w_instr_nx    = r_instr;
    w_id_pc_nx    = r_id_pc;
    w_id_pc4_nx   = r_id_pc4;
    w_fault_nx    = r_fault;
    w_fault_pc_nx = r_fault_pc;

    case (r_state)
      S_RUN: begin
        if (redirect) begin
          // Flush wins over stall: the instruction in IF/ID is on the wrong path.
          w_valid_nx = 1'b0;
          w_instr_nx = NOP_INSTR;
          if (w_redir_legal) begin
            w_pc_nx = redirect_pc;
          end else begin
            w_fault_pc_nx = redirect_pc;
            w_fault_nx    = 1'b1;
            w_state_nx    = S_FAULT;
          end
        end else if (stall) begin
          w_state_nx = S_RUN;
        end else if (!w_pc_legal) begin
          w_valid_nx    = 1'b0;
          w_fault_pc_nx = r_pc;
          w_fault_nx    = 1'b1;
          w_state_nx    = S_FAULT;
        end else begin
          w_valid_nx  = 1'b1;
          w_instr_nx  = imem_instr;
          w_id_pc_nx  = r_pc;
          w_id_pc4_nx = w_pc_plus4;
          w_pc_nx     = w_pc_plus4;
        end
      end

      S_FAULT: begin
        w_valid_nx = 1'b0;
        if (redirect) begin
          if (w_redir_legal) begin
            w_pc_nx    = redirect_pc;
            w_fault_nx = 1'b0;
            w_state_nx = S_RUN;
          end else begin
            w_fault_pc_nx = redirect_pc;
          end
        end
      end

      default: begin
        // BOOT (and any unused encoding): one bubble cycle before fetching.
        w_valid_nx = 1'b0;
        w_state_nx = S_RUN;
        if (redirect) begin
          w_instr_nx = NOP_INSTR;
          if (w_redir_legal) begin
            w_pc_nx = redirect_pc;
          end else begin
            w_fault_pc_nx = redirect_pc;
            w_fault_nx    = 1'b1;
            w_state_nx    = S_FAULT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_id_pc    <= 32'd0;
      r_id_pc4   <= 32'd0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'd0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_valid    <= w_valid_nx;
      r_instr    <= w_instr_nx;
      r_id_pc    <= w_id_pc_nx;
      r_id_pc4   <= w_id_pc4_nx;
      r_fault    <= w_fault_nx;
      r_fault_pc <= w_fault_pc_nx;
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_valid = r_valid;
  assign if_id_instr = r_instr;
  assign if_id_pc    = r_id_pc;
  assign if_id_pc4   = r_id_pc4;
  assign fetch_fault = r_fault;
  assign fault_pc    = r_fault_pc;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_stage : directed self-checking bench for if_stage                  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_errors = 0;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(256),
    .NOP_INSTR (32'h0000_0013)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_pc4  (if_id_pc4),
    .fetch_fault(fetch_fault),
    .fault_pc   (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: three real instructions, everything else tagged with its address.
  always_comb begin
    case (imem_addr)
      32'h0:   imem_instr = 32'h00A0_0093;
      32'h4:   imem_instr = 32'h0010_0113;
      32'h8:   imem_instr = 32'h0020_81B3;
      default: imem_instr = 32'hA000_0000 | imem_addr;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cap(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, 32'd1);
    chk({tag, ".pc"},    if_id_pc,  pc);
    chk({tag, ".pc4"},   if_id_pc4, pc + 32'd4);
    chk({tag, ".instr"}, if_id_instr, instr);
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    #12;
    chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst.instr", if_id_instr, 32'h13);
    chk("rst.addr",  imem_addr, 32'h0);
    chk("rst.idpc",  if_id_pc, 32'h0);
    chk("rst.pc4",   if_id_pc4, 32'h0);
    chk("rst.fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst.fpc",   fault_pc, 32'h0);

    @(posedge clk); #1;
    reset = 1'b0;
    step();
    chk("boot.valid", {31'd0, if_id_valid}, 32'd0);
    chk("boot.addr",  imem_addr, 32'h0);
    step(); chk_cap("cap0", 32'h0, 32'h00A0_0093);
    step(); chk_cap("cap4", 32'h4, 32'h0010_0113);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.idpc", if_id_pc, 32'h4);
      chk("stall.addr", imem_addr, 32'h8);
    end
    stall = 1'b0;
    step(); chk_cap("cap8", 32'h8, 32'h0020_81B3);
    chk("cap8.addr", imem_addr, 32'hC);

    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("flush.valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush.instr", if_id_instr, 32'h13);
    chk("flush.addr",  imem_addr, 32'h40);
    step(); chk_cap("cap40", 32'h40, 32'hA000_0040);

    redirect = 1'b1; redirect_pc = 32'h22;
    step();
    redirect = 1'b0; stall = 1'b1;
    chk("mis.fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis.fpc",   fault_pc, 32'h22);
    chk("mis.addr",  imem_addr, 32'h44);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mis.valid", {31'd0, if_id_valid}, 32'd0);
      chk("mis.hold",  {31'd0, fetch_fault}, 32'd1);
    end
    stall = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    chk("rec.fault", {31'd0, fetch_fault}, 32'd0);
    chk("rec.addr",  imem_addr, 32'h10);
    chk("rec.valid", {31'd0, if_id_valid}, 32'd0);
    step(); chk_cap("cap10", 32'h10, 32'hA000_0010);

    redirect = 1'b1; redirect_pc = 32'hF8;
    step();
    redirect = 1'b0;
    step(); chk_cap("capF8", 32'hF8, 32'hA000_00F8);
    step(); chk_cap("capFC", 32'hFC, 32'hA000_00FC);
    chk("end.addr", imem_addr, 32'h100);
    step();
    chk("end.fault", {31'd0, fetch_fault}, 32'd1);
    chk("end.fpc",   fault_pc, 32'h100);
    chk("end.valid", {31'd0, if_id_valid}, 32'd0);
    chk("end.idpc",  if_id_pc, 32'hFC);

    redirect = 1'b1; redirect_pc = 32'h104;
    step();
    chk("oob.fpc",   fault_pc, 32'h104);
    chk("oob.fault", {31'd0, fetch_fault}, 32'd1);
    redirect_pc = 32'h4;
    step();
    redirect = 1'b0;
    step(); chk_cap("cap4b", 32'h4, 32'h0010_0113);

    #3 reset = 1'b1;
    #1;
    chk("arst.valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst.addr",  imem_addr, 32'h0);
    chk("arst.instr", if_id_instr, 32'h13);
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    chk("arst.boot", {31'd0, if_id_valid}, 32'd0);
    step(); chk_cap("arst.cap0", 32'h0, 32'h00A0_0093);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
